// File: rtl/csr_arb_pkg.sv
// Shared definitions for the CSR host arbiter: FSM state encoding and the
// default idle-timeout used when the top is instantiated without overrides.
package csr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/csr_host_arbiter_if.sv
// Host-side bus of the CSR arbiter: per-host request/strobe/write lanes,
// one-hot grant, shared read data and per-host completion/abort pulses.
// The arbiter uses the slave view; host bridges (or a bench) use the master view.
interface csr_host_arbiter_if #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);

  logic [NUM_M-1:0]        req;
  logic [NUM_M-1:0]        gnt;
  logic [NUM_M-1:0]        stb;
  logic [NUM_M-1:0]        we;
  logic [NUM_M*ADDR_W-1:0] addr;
  logic [NUM_M*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]       rdata;
  logic [NUM_M-1:0]        rvalid;
  logic [NUM_M-1:0]        abort;

  modport master (
    output req, stb, we, addr, wdata,
    input  gnt, rdata, rvalid, abort
  );

  modport slave (
    input  req, stb, we, addr, wdata,
    output gnt, rdata, rvalid, abort
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: searches the eligible vector starting
// one past the last owner and returns the winner as a one-hot vector and an
// index. Pure logic, so it can be reused by other arbiters (e.g. PROM write port).
module rr_pick #(
  parameter int NUM_M = 2,
  parameter int IDX_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] eligible,
  input  logic [IDX_W-1:0] last,
  output logic [NUM_M-1:0] pick,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   cand;

  // Walk the hosts in rotated order and keep the first eligible one.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = (int'(last) + k) % NUM_M;
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found                  = 1'b1;
        pick[cand[IDX_W-1:0]]  = 1'b1;
        idx                    = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/csr_host_arbiter.sv
// Shares the byte-wide CSR register-file port between NUM_M host bridges.
// A grant is held for a whole transaction (while the owner keeps req high),
// accesses are pipelined one per cycle (csr drive at T+1, rvalid at T+2),
// and a stalled owner is forcibly released after TIMEOUT idle cycles.
module csr_host_arbiter
  import csr_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  csr_host_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [DATA_W-1:0] csr_wdata,
  output logic              csr_ack,
  input  logic [DATA_W-1:0] csr_rdata
);

  localparam int IDX_W = $clog2(NUM_M);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_t        state;
  logic [NUM_M-1:0]  gnt_q;
  logic [IDX_W-1:0]  owner;
  logic [CNT_W-1:0]  idle_cnt;
  logic              drain_cnt;
  logic [NUM_M-1:0]  block;

  logic [NUM_M-1:0]  s1_vec;
  logic [NUM_M-1:0]  rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [NUM_M-1:0]  eligible;
  logic [NUM_M-1:0]  pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              owner_req;
  logic              accept;
  logic              timeout_hit;

  logic [ADDR_W-1:0] addr_arr  [NUM_M];
  logic [DATA_W-1:0] wdata_arr [NUM_M];

  for (genvar g = 0; g < NUM_M; g++) begin : g_unpack
    assign addr_arr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.wdata[g*DATA_W +: DATA_W];
  end

  // Blocked hosts (timed out, req still high) are not eligible.
  assign eligible = bus.req & ~block;

  // The grant register is only non-zero in ST_GRANT, so masking with it
  // both selects the owner and ignores non-owner strobes.
  assign owner_req   = |(bus.req & gnt_q);
  assign accept      = |(bus.stb & bus.req & gnt_q);
  assign timeout_hit = TIMEOUT_EN && (state == ST_GRANT) && owner_req &&
                       !accept && (idle_cnt == CNT_MAX);

  rr_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .last     (owner),
    .pick     (pick),
    .idx      (pick_idx)
  );

  // Arbitration FSM: grant, hold for the transaction, release or time out, drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt_q     <= '0;
      owner     <= IDX_W'(NUM_M - 1);
      idle_cnt  <= '0;
      drain_cnt <= 1'b0;
      block     <= '0;
    end else begin
      block <= (block & bus.req) | (timeout_hit ? gnt_q : '0);
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state    <= ST_GRANT;
            gnt_q    <= pick;
            owner    <= pick_idx;
            idle_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (!owner_req) begin
            gnt_q     <= '0;
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end else if (accept) begin
            idle_cnt <= '0;
          end else if (timeout_hit) begin
            gnt_q     <= '0;
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state <= ST_IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  // Two-stage access pipeline: drive the csr port, then capture read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_addr  <= '0;
      csr_wdata <= '0;
      csr_ack   <= 1'b0;
      s1_vec    <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      csr_ack  <= 1'b0;
      s1_vec   <= '0;
      rvalid_q <= s1_vec;
      if (accept) begin
        csr_addr  <= addr_arr[owner];
        csr_wdata <= wdata_arr[owner];
        csr_ack   <= |(bus.we & gnt_q);
        s1_vec    <= gnt_q;
      end
      if (|s1_vec) begin
        rdata_q <= csr_rdata;
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  // Abort must show in the final idle cycle itself, so it is decoded directly.
  assign bus.abort  = timeout_hit ? gnt_q : '0;

endmodule

// File: tb/tb_csr_host_arbiter.sv
// Scoreboard bench for csr_host_arbiter: stimulus pushes expected grant,
// csr-write, completion and abort events (with their exact cycle) into
// queues; a negedge monitor pops and compares whenever the DUT shows one.
module tb_csr_host_arbiter;

  localparam int NUM_M  = 2;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  typedef struct {
    int          host;
    logic [11:0] addr;
    logic [7:0]  data;
    int          cyc;
  } ev_t;

  logic clk;
  logic rst;
  logic [ADDR_W-1:0] csr_addr;
  logic [DATA_W-1:0] csr_wdata;
  logic              csr_ack;
  logic [DATA_W-1:0] csr_rdata;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [NUM_M-1:0] prev_gnt = '0;

  ev_t gnt_q[$];
  ev_t wr_q[$];
  ev_t rv_q[$];
  ev_t ab_q[$];

  csr_host_arbiter_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  csr_host_arbiter #(
    .NUM_M   (NUM_M),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_ack   (csr_ack),
    .csr_rdata (csr_rdata)
  );

  // CSR model: read data is the low address byte.
  assign csr_rdata = csr_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(int n);
    repeat (n) step();
  endtask

  task automatic goto_cycle(int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 1000) begin
      step();
      guard++;
    end
  endtask

  task automatic push_gnt(int h, int c);
    ev_t e;
    e.host = h; e.addr = '0; e.data = '0; e.cyc = c;
    gnt_q.push_back(e);
  endtask

  task automatic push_abort(int h, int c);
    ev_t e;
    e.host = h; e.addr = '0; e.data = '0; e.cyc = c;
    ab_q.push_back(e);
  endtask

  task automatic push_wr(int h, logic [11:0] a, logic [7:0] d, int c);
    ev_t e;
    e.host = h; e.addr = a; e.data = d; e.cyc = c;
    wr_q.push_back(e);
  endtask

  task automatic push_rv(int h, logic [7:0] d, int c);
    ev_t e;
    e.host = h; e.addr = '0; e.data = d; e.cyc = c;
    rv_q.push_back(e);
  endtask

  // One strobe cycle from host h; expected events pushed only if it should be accepted.
  task automatic apply_access(int h, bit w, logic [11:0] a, logic [7:0] d, bit ok);
    bus.stb[h] = 1'b1;
    bus.we[h]  = w;
    bus.addr[h*ADDR_W +: ADDR_W]  = a;
    bus.wdata[h*DATA_W +: DATA_W] = d;
    if (ok) begin
      if (w) push_wr(h, a, d, cyc + 1);
      push_rv(h, a[7:0], cyc + 2);
    end
    step();
    bus.stb[h] = 1'b0;
    bus.we[h]  = 1'b0;
  endtask

  // Monitor: invariants every cycle, and scoreboard pops on every DUT event.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      check_output("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
      check_output("rvalid_onehot0", 32'($onehot0(bus.rvalid)), 1);
    end
    if (bus.gnt != '0 && bus.gnt != prev_gnt) begin
      if (gnt_q.size() == 0) check_output("gnt_unexpected", 32'(bus.gnt), 0);
      else begin
        e = gnt_q.pop_front();
        check_output("gnt_host", 32'(bus.gnt), 32'(1) << e.host);
        check_output("gnt_cycle", cyc, e.cyc);
      end
    end
    prev_gnt = bus.gnt;
    if (csr_ack) begin
      if (wr_q.size() == 0) check_output("ack_unexpected", 32'(csr_ack), 0);
      else begin
        e = wr_q.pop_front();
        check_output("ack_addr", 32'(csr_addr), 32'(e.addr));
        check_output("ack_wdata", 32'(csr_wdata), 32'(e.data));
        check_output("ack_cycle", cyc, e.cyc);
      end
    end
    if (bus.rvalid != '0) begin
      if (rv_q.size() == 0) check_output("rvalid_unexpected", 32'(bus.rvalid), 0);
      else begin
        e = rv_q.pop_front();
        check_output("rvalid_host", 32'(bus.rvalid), 32'(1) << e.host);
        check_output("rdata", 32'(bus.rdata), 32'(e.data));
        check_output("rvalid_cycle", cyc, e.cyc);
      end
    end
    if (bus.abort != '0) begin
      if (ab_q.size() == 0) check_output("abort_unexpected", 32'(bus.abort), 0);
      else begin
        e = ab_q.pop_front();
        check_output("abort_host", 32'(bus.abort), 32'(1) << e.host);
        check_output("abort_cycle", cyc, e.cyc);
      end
    end
  end

  // Hard bound on the whole run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int t;
    rst = 1'b1;
    bus.req = '0; bus.stb = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    tick(3);
    check_output("rst_gnt", 32'(bus.gnt), 0);
    check_output("rst_rvalid", 32'(bus.rvalid), 0);
    check_output("rst_abort", 32'(bus.abort), 0);
    check_output("rst_rdata", 32'(bus.rdata), 0);
    check_output("rst_csr_addr", 32'(csr_addr), 0);
    check_output("rst_csr_wdata", 32'(csr_wdata), 0);
    check_output("rst_csr_ack", 32'(csr_ack), 0);
    rst = 1'b0;
    step();

    // Single host write
    bus.req[0] = 1'b1;
    push_gnt(0, cyc + 1);
    step();
    apply_access(0, 1'b1, 12'h010, 8'h5A, 1'b1);
    bus.req[0] = 1'b0;
    step();
    check_output("t1_gnt_released", 32'(bus.gnt), 0);
    check_output("t1_addr_hold", 32'(csr_addr), 32'h010);
    check_output("t1_wdata_hold", 32'(csr_wdata), 32'h5A);
    tick(4);

    // Pipelined reads from host1
    bus.req[1] = 1'b1;
    push_gnt(1, cyc + 1);
    step();
    for (int i = 0; i < 4; i++) apply_access(1, 1'b0, 12'h100 + 12'(i), 8'h00, 1'b1);
    bus.req[1] = 1'b0;
    step();
    tick(4);

    // Round-robin: both hosts requesting, order 0,1,0,1
    t = cyc;
    bus.req[0] = 1'b1;
    bus.req[1] = 1'b1;
    push_gnt(0, t + 1);
    step();
    for (int i = 0; i < 3; i++) apply_access(0, 1'b0, 12'h020 + 12'(i), 8'h00, 1'b1);
    bus.req[0] = 1'b0;
    push_gnt(1, t + 8);
    step();
    bus.req[0] = 1'b1;
    goto_cycle(t + 8);
    for (int i = 0; i < 3; i++) apply_access(1, 1'b0, 12'h030 + 12'(i), 8'h00, 1'b1);
    bus.req[1] = 1'b0;
    push_gnt(0, t + 15);
    step();
    bus.req[1] = 1'b1;
    goto_cycle(t + 15);
    for (int i = 0; i < 3; i++) apply_access(0, 1'b1, 12'h040 + 12'(i), 8'h90 + 8'(i), 1'b1);
    bus.req[0] = 1'b0;
    push_gnt(1, t + 22);
    goto_cycle(t + 22);
    for (int i = 0; i < 3; i++) apply_access(1, 1'b0, 12'h050 + 12'(i), 8'h00, 1'b1);
    bus.req[1] = 1'b0;
    step();
    tick(4);

    // Non-owner strobe, and owner strobe in its req-fall cycle
    t = cyc;
    bus.req[0] = 1'b1;
    push_gnt(0, t + 1);
    step();
    apply_access(1, 1'b1, 12'h055, 8'hEE, 1'b0);
    bus.req[0] = 1'b0;
    apply_access(0, 1'b1, 12'h066, 8'h77, 1'b0);
    check_output("t4_gnt_low", 32'(bus.gnt), 0);
    check_output("t4_no_ack", 32'(csr_ack), 0);
    tick(4);

    // Timeout on host0, host1 served, host0 blocked until it drops req
    t = cyc;
    bus.req[0] = 1'b1;
    push_gnt(0, t + 1);
    step();
    step();
    bus.req[1] = 1'b1;
    push_abort(0, t + 8);
    push_gnt(1, t + 12);
    goto_cycle(t + 9);
    check_output("t5_gnt_after_abort", 32'(bus.gnt), 0);
    goto_cycle(t + 12);
    apply_access(1, 1'b1, 12'h0F0, 8'hC3, 1'b1);
    bus.req[1] = 1'b0;
    goto_cycle(t + 20);
    check_output("t5_blocked", 32'(bus.gnt), 0);
    bus.req[0] = 1'b0;
    step();
    bus.req[0] = 1'b1;
    push_gnt(0, t + 22);
    step();
    apply_access(0, 1'b0, 12'h0F1, 8'h00, 1'b1);
    bus.req[0] = 1'b0;
    step();
    tick(4);

    // Strobe on the would-be timeout cycle wins
    t = cyc;
    bus.req[1] = 1'b1;
    push_gnt(1, t + 1);
    goto_cycle(t + 8);
    apply_access(1, 1'b0, 12'h0AB, 8'h00, 1'b1);
    bus.req[1] = 1'b0;
    step();
    tick(4);

    // Reset in the cycle after a write strobe
    t = cyc;
    bus.req[0] = 1'b1;
    push_gnt(0, t + 1);
    step();
    push_wr(0, 12'h0AA, 8'h33, t + 2);
    apply_access(0, 1'b1, 12'h0AA, 8'h33, 1'b0);
    rst = 1'b1;
    bus.req[0] = 1'b0;
    step();
    rst = 1'b0;
    check_output("t6_ack", 32'(csr_ack), 0);
    check_output("t6_rvalid", 32'(bus.rvalid), 0);
    check_output("t6_gnt", 32'(bus.gnt), 0);
    check_output("t6_rdata", 32'(bus.rdata), 0);
    check_output("t6_csr_addr", 32'(csr_addr), 0);
    bus.req[1] = 1'b1;
    push_gnt(1, cyc + 1);
    step();
    check_output("t6_regrant", 32'(bus.gnt), 32'h2);
    bus.req[1] = 1'b0;
    step();
    tick(4);

    check_output("left_gnt_events", gnt_q.size(), 0);
    check_output("left_wr_events", wr_q.size(), 0);
    check_output("left_rv_events", rv_q.size(), 0);
    check_output("left_abort_events", ab_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_host_arbiter.md
Name: csr_host_arbiter

Overview:
Shares the byte-wide CSR register-file access port (12-bit addr, 8-bit wdata, write ack strobe, combinational read data) between NUM_M host bridges, e.g. the SPI bridge and a second host (UART/debug). Hosts hold a request for a whole transaction. Grants are round-robin and latched per transaction, and accesses are pipelined at one per cycle. An idle-timeout forcibly revokes a grant from a stalled host. Sits between the host bridges and the csr register file.

Parameters:
NUM_M, 2, number of requesting hosts (2..4)
ADDR_W, 12, CSR address width
DATA_W, 8, CSR data width
TIMEOUT, 1024, idle cycles while granted before forced release; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_req_i  in  NUM_M  per-host transaction request, held for whole transaction
m_gnt_o  out  NUM_M  one-hot grant (registered)
m_stb_i  in  NUM_M  per-host access strobe, one access per cycle
m_we_i  in  NUM_M  per-host write enable, qualified by stb
m_addr_i  in  NUM_M*ADDR_W  per-host address, host i at [i*ADDR_W +: ADDR_W]
m_wdata_i  in  NUM_M*DATA_W  per-host write data
m_rdata_o  out  DATA_W  shared read data, valid with m_rvalid_o
m_rvalid_o  out  NUM_M  per-host access-complete pulse (reads and writes)
m_abort_o  out  NUM_M  one-cycle pulse: grant revoked by timeout
csr_addr_o  out  ADDR_W  address to csr
csr_wdata_o  out  DATA_W  write data to csr
csr_ack_o  out  1  one-cycle write strobe to csr
csr_rdata_i  in  DATA_W  csr read data, combinational from csr_addr_o

Behaviour:
- Reset values: m_gnt_o=0, m_rvalid_o=0, m_abort_o=0, m_rdata_o=0, csr_addr_o=0, csr_wdata_o=0, csr_ack_o=0. The RR pointer gives host 0 highest priority. The timeout counter is 0. All block bits are 0. The FSM is in ST_IDLE.
- FSM states:
  - ST_IDLE: the eligible set is m_req_i & ~block. If the set is non-empty, pick the first eligible host starting at (last_owner+1) mod NUM_M. Set owner, last_owner=owner, m_gnt_o[owner]=1 next cycle. Go to ST_GRANT. Latency: req at cycle T gives gnt high at T+1.
  - ST_GRANT: an access is accepted at cycle T when m_stb_i[owner] & m_req_i[owner] & m_gnt_o[owner].
    - T+1: csr_addr_o=addr and csr_wdata_o=wdata of owner; csr_ack_o=we for exactly 1 cycle.
    - T+2: m_rdata_o<=csr_rdata_i (sampled at T+1); m_rvalid_o[owner]=1 for 1 cycle.
    - Back-to-back strobes are allowed, giving throughput of 1 access/cycle.
    - Strobes from non-owners, or from the owner while its req is low, are ignored: no csr activity and no rvalid.
  - Release: when m_req_i[owner] falls, m_gnt_o drops next cycle and the FSM enters ST_DRAIN.
  - ST_DRAIN: lasts 2 cycles so in-flight accesses complete with rvalid. Then ST_IDLE. A new grant is issued no earlier than the cycle after leaving ST_DRAIN.
  - Timeout: applies when TIMEOUT>0.
    - The counter increments each ST_GRANT cycle without an accepted strobe. It clears on an accepted strobe and on every new grant.
    - When it reaches TIMEOUT-1 with no strobe: m_abort_o[owner] pulses 1 cycle, m_gnt_o drops next cycle, block[owner]=1, and the FSM goes to ST_DRAIN.
    - block[i] clears when m_req_i[i] is low. A blocked host must drop req before it can be granted again.
- csr_addr_o and csr_wdata_o hold their last values when idle. csr_ack_o is only ever asserted in the cycle after an accepted write strobe.
- Simultaneous events:
  - A req fall and a strobe in the same cycle: the strobe is ignored.
  - A timeout tick and an accepted strobe in the same cycle: the strobe wins and the counter clears.
- Reset mid-transaction: everything returns to reset values immediately. In-flight accesses are discarded with no rvalid. A csr_ack_o pending for the next cycle is not issued.
- m_gnt_o is always one-hot or zero. At most one m_rvalid_o bit is set per cycle.

Decomposition:
- Shared package csr_arb_pkg: FSM state constants ST_IDLE/ST_GRANT/ST_DRAIN, and a default TIMEOUT constant.
- One natural sub-module, rr_pick: combinational round-robin selector. Inputs are the eligible vector and last_owner. Outputs are the one-hot pick and its index. It is reusable for the PROM write-port arbiter.

Test Plan:
- Single host: host0 req, then a write strobe with addr=0x010 and wdata=0x5A at T. Expect gnt0 at req+1; csr_addr_o=0x010, csr_wdata_o=0x5A, csr_ack_o=1 at T+1; rvalid0 at T+2.
- Pipelined reads: host1 issues 4 back-to-back read strobes to addr 0x100..0x103 while the csr model returns addr[7:0]. Expect rvalid1 on 4 consecutive cycles with rdata 0x00,0x01,0x02,0x03, and csr_ack_o never set.
- Round-robin: both hosts hold req continuously after reset, each transaction 3 accesses then drops req and re-raises it. Expect grant order 0,1,0,1 and never both gnt bits set.
- Non-owner and dropped strobes: host1 strobes while host0 is owner; host0 strobes in its req-fall cycle. Expect no csr_ack_o, no rvalid for either, and gnt0 low the next cycle.
- Timeout: TIMEOUT=8, host0 granted and idle. Expect abort0 on the 8th idle cycle and gnt0 low next cycle. Host1 req pending is granted after drain. Host0 keeping req high is not re-granted until it drops req.
- Reset mid-op: assert rst in the cycle after a write strobe. Expect csr_ack_o=0, no rvalid, gnt=0, and a subsequent host1-only req granted at req+1.
